pc_sequencer: RTL and testbench

- Multi-cycle fetch/execute controller that owns the word-indexed program counter of the single-cycle MIPS core.
- Issues instruction-memory fetches with a req/ack handshake.
- Applies branch and jump redirects supplied by the decoder.
- Retires one instruction per EXEC cycle and stops the program cleanly via a done flag once the PC passes the last instruction index, with no simulator $finish.

---
 rtl/pc_seq_pkg.sv | 24 ++
 rtl/pc_next_calc.sv | 25 ++
 rtl/pc_sequencer.sv | 139 +++++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the PC sequencer: FSM states, redirect
// select codes and the jump-target concatenation.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PC_INC = 2'd0,
    PC_BR  = 2'd1,
    PC_JMP = 2'd2
  } pc_sel_t;

  // Jump keeps the top nibble of the current PC; the field is word-indexed.
  function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                              input logic [25:0] addr);
    return {pc[31:28], 2'b00, addr};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential, branch-relative or jump.
module pc_next_calc
  import pc_seq_pkg::*;
(
  input  logic    [31:0] pc,
  input  pc_sel_t        sel,
  input  logic    [31:0] imm,
  input  logic    [25:0] jaddr,
  output logic    [31:0] next_pc
);

  logic [31:0] pc_inc;

  // Modulo-2^32 arithmetic; wrap-around is legal and simply lands out of range.
  always_comb begin
    pc_inc  = pc + 32'd1;
    next_pc = pc_inc;
    case (sel)
      PC_BR:   next_pc = pc_inc + imm;
      PC_JMP:  next_pc = jump_target(pc, jaddr);
      default: next_pc = pc_inc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute controller owning the word-indexed PC. Fetches with a
// req/ack handshake, applies decoder redirects in EXEC and halts with done
// once the PC passes LAST_INDEX (error marks a fetch timeout halt).
// Optional macro PC_SEQ_PERF_EN adds retire and redirect counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [31:0] LAST_INDEX  = 32'd20,
  parameter int          MEM_TIMEOUT = 8
) (
  input  logic        clk2,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        branch,
  input  logic        jumpp,
  input  logic [31:0] SignExtImm,
  input  logic [25:0] jumpAdress,
  output logic [31:0] pc_out,
  output logic        retire,
  output logic        busy,
  output logic        done,
  output logic        error
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0] instr_count,
  output logic [31:0] redirect_count
`endif
);

  // Counter value seen on the last FETCH cycle before giving up.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state;
  logic [31:0] pc;
  logic [7:0]  tmo_cnt;
  pc_sel_t     sel;
  logic [31:0] next_pc;

  assign pc_out    = pc;
  assign imem_addr = pc;

  // Jump outranks branch when the decoder asserts both.
  always_comb begin
    sel = PC_INC;
    if (jumpp)       sel = PC_JMP;
    else if (branch) sel = PC_BR;
  end

  pc_next_calc u_next (
    .pc      (pc),
    .sel     (sel),
    .imm     (SignExtImm),
    .jaddr   (jumpAdress),
    .next_pc (next_pc)
  );

  // Main FSM; outputs are registered alongside the state they belong to.
  always_ff @(negedge clk2) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      imem_req <= 1'b0;
      retire   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      tmo_cnt  <= 8'd0;
    end else begin
      retire <= 1'b0;
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            error    <= 1'b0;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            tmo_cnt  <= 8'd0;
          end
        end
        FETCH: begin
          // An ack on the expiring cycle still counts as a good fetch.
          if (imem_ack) begin
            state    <= EXEC;
            imem_req <= 1'b0;
            retire   <= 1'b1;
            tmo_cnt  <= 8'd0;
          end else if (tmo_cnt == TMO_LAST) begin
            state    <= HALT;
            imem_req <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            error    <= 1'b1;
            tmo_cnt  <= 8'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        EXEC: begin
          pc <= next_pc;
          if (next_pc > LAST_INDEX) begin
            state <= HALT;
            busy  <= 1'b0;
            done  <= 1'b1;
            error <= 1'b0;
          end else begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic accept_start;
  assign accept_start = start && (state == IDLE || state == HALT);

  // Saturating retire and redirect counters, cleared on each new run.
  always_ff @(negedge clk2) begin
    if (reset || accept_start) begin
      instr_count    <= 32'd0;
      redirect_count <= 32'd0;
    end else if (state == EXEC) begin
      if (instr_count != 32'hFFFF_FFFF)
        instr_count <= instr_count + 32'd1;
      if ((branch || jumpp) && redirect_count != 32'hFFFF_FFFF)
        redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential run, redirects, timeout,
// reset mid-fetch, and a second instance with a high LAST_INDEX for the
// jump-over-branch case at a large PC.
module tb_pc_sequencer;

  logic        clk2 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        imem_ack = 1'b0;
  logic        branch = 1'b0;
  logic        jumpp = 1'b0;
  logic [31:0] SignExtImm = 32'd0;
  logic [25:0] jumpAdress = 26'd0;

  logic        imem_req, retire, busy, done, error;
  logic [31:0] imem_addr, pc_out;
  logic        req2, ret2, busy2, done2, err2;
  logic [31:0] addr2, pc2;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] instr_count, redirect_count, ic2, rc2;
`endif

  pc_sequencer dut (
    .clk2(clk2), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .branch(branch), .jumpp(jumpp), .SignExtImm(SignExtImm),
    .jumpAdress(jumpAdress), .pc_out(pc_out), .retire(retire),
    .busy(busy), .done(done), .error(error)
`ifdef PC_SEQ_PERF_EN
    , .instr_count(instr_count), .redirect_count(redirect_count)
`endif
  );

  pc_sequencer #(.LAST_INDEX(32'h3000_0004)) dut_hi (
    .clk2(clk2), .reset(reset), .start(start),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(imem_ack),
    .branch(branch), .jumpp(jumpp), .SignExtImm(SignExtImm),
    .jumpAdress(jumpAdress), .pc_out(pc2), .retire(ret2),
    .busy(busy2), .done(done2), .error(err2)
`ifdef PC_SEQ_PERF_EN
    , .instr_count(ic2), .redirect_count(rc2)
`endif
  );

  always #5 clk2 = ~clk2;

  int npass = 0;
  int ntotal = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // DUT moves on negedge; drive and sample 1 time unit after it.
  task automatic tick;
    @(negedge clk2);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // From FETCH: ack, then present decoder inputs during EXEC.
  task automatic exec_one(input logic br, input logic jp, input logic [31:0] imm,
                          input logic [25:0] ja, output logic ret);
    imem_ack = 1'b1;
    tick();
    imem_ack   = 1'b0;
    branch     = br;
    jumpp      = jp;
    SignExtImm = imm;
    jumpAdress = ja;
    ret = retire;
    tick();
    branch     = 1'b0;
    jumpp      = 1'b0;
    SignExtImm = 32'd0;
    jumpAdress = 26'd0;
  endtask

  initial begin
    logic r;
    int   rcnt;
    int   n;

    tick();
    tick();
    reset = 1'b0;
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_flags", {28'd0, retire, busy, done, error}, 32'd0);

    // Sequential run 0..20
    pulse_start();
    chk("start_req", {31'd0, imem_req}, 32'd1);
    rcnt = 0;
    for (int i = 0; i <= 20; i++) begin
      chk("seq_addr", imem_addr, 32'(i));
      exec_one(1'b0, 1'b0, 32'd0, 26'd0, r);
      if (r) rcnt++;
    end
    chk("seq_retires", 32'(rcnt), 32'd21);
    chk("seq_done", {31'd0, done}, 32'd1);
    chk("seq_pc", pc_out, 32'd21);
    chk("seq_err", {31'd0, error}, 32'd0);
    chk("seq_busy", {31'd0, busy}, 32'd0);
`ifdef PC_SEQ_PERF_EN
    chk("perf_seq_ic", instr_count, 32'd21);
    chk("perf_seq_rc", redirect_count, 32'd0);
`endif

    // Redirects
    pulse_start();
    for (int i = 0; i < 3; i++) exec_one(1'b0, 1'b0, 32'd0, 26'd0, r);
    chk("pre_br_addr", imem_addr, 32'd3);
    exec_one(1'b1, 1'b0, 32'd4, 26'd0, r);
    chk("fwd_branch", imem_addr, 32'd8);
    exec_one(1'b0, 1'b1, 32'd0, 26'h5, r);
    chk("jump", imem_addr, 32'd5);
    exec_one(1'b1, 1'b0, 32'hFFFF_FFFD, 26'd0, r);
    chk("back_branch", imem_addr, 32'd3);
    exec_one(1'b1, 1'b1, 32'd4, 26'h15, r);
    chk("jmp_prio_pc", pc_out, 32'd21);
    chk("jmp_prio_done", {31'd0, done}, 32'd1);
`ifdef PC_SEQ_PERF_EN
    chk("perf_br_ic", instr_count, 32'd7);
    chk("perf_br_rc", redirect_count, 32'd4);
`endif

    // Fetch timeout
    pulse_start();
    n = 0;
    while (imem_req && n < 20) begin
      n++;
      tick();
    end
    chk("tmo_cycles", 32'(n), 32'd8);
    chk("tmo_done", {31'd0, done}, 32'd1);
    chk("tmo_err", {31'd0, error}, 32'd1);
    chk("tmo_pc", pc_out, 32'd0);

    // Restart clears error; ack on the expiring cycle wins
    pulse_start();
    chk("restart_err", {31'd0, error}, 32'd0);
    chk("restart_addr", imem_addr, 32'd0);
    repeat (7) tick();
    chk("late_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("late_ack_retire", {31'd0, retire}, 32'd1);
    chk("late_ack_err", {31'd0, error}, 32'd0);
    tick();
    chk("mid_req", {31'd0, imem_req}, 32'd1);
    chk("mid_pc", pc_out, 32'd1);

    // Reset mid-fetch
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc", pc_out, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);

    // Ack in IDLE is ignored
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("idle_ack", {29'd0, busy, done, imem_req}, 32'd0);

    // Jump+branch at a high PC on the wide-range instance
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulse_start();
    exec_one(1'b1, 1'b0, 32'h3000_0001, 26'd0, r);
    chk("lo_wrap_done", {31'd0, done}, 32'd1);
    chk("lo_wrap_pc", pc_out, 32'h3000_0002);
    chk("hi_addr", addr2, 32'h3000_0002);
    chk("hi_req", {31'd0, req2}, 32'd1);
    exec_one(1'b1, 1'b1, 32'd4, 26'h5, r);
    chk("hi_jmp_pc", pc2, 32'h3000_0005);
    chk("hi_done", {31'd0, done2}, 32'd1);
    chk("hi_err", {31'd0, err2}, 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
